// File: rtl/hex_frame_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hex_frame_pkg
//  Description : Shared ASCII constants and FSM state encoding for the
//                hex frame sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package hex_frame_pkg;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_X  = 8'h78;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // Frame sequencer states, in emission order
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PFX0 = 3'd1,
        PFX1 = 3'd2,
        HEX  = 3'd3,
        CR   = 3'd4,
        LF   = 3'd5
    } hf_state_t;

endpackage : hex_frame_pkg
`default_nettype wire

// File: rtl/hex_to_ascii.sv
`default_nettype none
// ============================================================================
//  Module      : hex_to_ascii
//  Description : Combinational 4-bit nibble to uppercase ASCII hex digit.
//  Revision    : 1.0 - initial release
// ============================================================================
module hex_to_ascii (
    input  logic [3:0] i_nibble,
    output logic [7:0] o_ascii
);

    // 0-9 map onto '0'..'9'; 10-15 map onto 'A'..'F' (0x37 + 10 = 0x41)
    always_comb begin
        o_ascii = 8'h00;
        if (i_nibble < 4'd10) begin
            o_ascii = {4'h3, i_nibble};
        end else begin
            o_ascii = 8'h37 + {4'h0, i_nibble};
        end
    end

endmodule : hex_to_ascii
`default_nettype wire

// File: rtl/hex_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : hex_frame_sequencer
//  Description : Captures an N-nibble word and streams it to a UART as
//                ASCII hex: optional "0x", digits MSB first, optional CR LF.
//  Revision    : 1.0 - initial release
// ============================================================================
module hex_frame_sequencer #(
    parameter int NIBBLES   = 4,
    parameter bit PREFIX_0X = 1'b0,
    parameter bit SEND_CRLF = 1'b1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [4*NIBBLES-1:0]   i_data,
    input  logic                   i_valid,
    output logic                   o_ready,
    output logic [7:0]             o_tx_data,
    output logic                   o_tx_valid,
    input  logic                   i_tx_ready,
    output logic                   o_busy
);
    import hex_frame_pkg::*;

    localparam int              IDXW     = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NIBBLES - 1);

    hf_state_t              state_q, state_d;
    logic [IDXW-1:0]        idx_q, idx_d;
    logic [4*NIBBLES-1:0]   word_q, word_d;
    logic                   tx_valid_q, tx_valid_d;
    logic [7:0]             tx_data_q, tx_data_d;

    logic                   tx_hs;
    logic                   load;
    logic [3:0]             nibble;
    logic [7:0]             hex_char;

    // Next-state logic: leave IDLE on accept, otherwise step only on a TX handshake
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        word_d  = word_q;
        tx_hs   = tx_valid_q && i_tx_ready;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    word_d  = i_data;
                    idx_d   = IDX_LAST;
                    state_d = PREFIX_0X ? PFX0 : HEX;
                    load    = 1'b1;
                end
            end
            PFX0: begin
                if (tx_hs) begin
                    state_d = PFX1;
                    load    = 1'b1;
                end
            end
            PFX1: begin
                if (tx_hs) begin
                    state_d = HEX;
                    load    = 1'b1;
                end
            end
            HEX: begin
                if (tx_hs) begin
                    load = 1'b1;
                    if (idx_q == '0) begin
                        state_d = SEND_CRLF ? CR : IDLE;
                    end else begin
                        idx_d = idx_q - IDXW'(1);
                    end
                end
            end
            CR: begin
                if (tx_hs) begin
                    state_d = LF;
                    load    = 1'b1;
                end
            end
            LF: begin
                if (tx_hs) begin
                    state_d = IDLE;
                    load    = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The registered output must show the character of the state being
    // entered, so the digit is taken from the word as it will be captured
    assign nibble = word_d[{idx_d, 2'b00} +: 4];

    hex_to_ascii u_hex_to_ascii (
        .i_nibble (nibble),
        .o_ascii  (hex_char)
    );

    // Output mux: reload the TX register on accept or handshake, hold otherwise
    always_comb begin
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        if (load) begin
            tx_valid_d = (state_d != IDLE);
            case (state_d)
                PFX0:    tx_data_d = ASCII_0;
                PFX1:    tx_data_d = ASCII_X;
                HEX:     tx_data_d = hex_char;
                CR:      tx_data_d = ASCII_CR;
                LF:      tx_data_d = ASCII_LF;
                default: tx_data_d = 8'h00;
            endcase
        end
    end

    // State, index, captured word and TX output registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            idx_q      <= IDX_LAST;
            word_q     <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            word_q     <= word_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign o_ready    = (state_q == IDLE);
    assign o_busy     = (state_q != IDLE);
    assign o_tx_valid = tx_valid_q;
    assign o_tx_data  = tx_data_q;

endmodule : hex_frame_sequencer
`default_nettype wire

// File: tb/tb_hex_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hex_frame_sequencer
//  Description : Directed self-checking bench for hex_frame_sequencer in
//                three configurations (default, 0x-prefix/no CRLF, 1 nibble).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hex_frame_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        tx_ready;

    // Default configuration: 4 nibbles, no prefix, CR LF
    logic [15:0] d_data;
    logic        d_valid, d_ready, d_tx_valid, d_busy;
    logic [7:0]  d_tx_data;
    // Prefix configuration: 4 nibbles, "0x", no CR LF
    logic [15:0] p_data;
    logic        p_valid, p_ready, p_tx_valid, p_busy;
    logic [7:0]  p_tx_data;
    // Single nibble configuration with CR LF
    logic [3:0]  n_data;
    logic        n_valid, n_ready, n_tx_valid, n_busy;
    logic [7:0]  n_tx_data;

    int n_tests = 0;
    int n_fail  = 0;

    hex_frame_sequencer #(.NIBBLES(4), .PREFIX_0X(1'b0), .SEND_CRLF(1'b1)) u_def (
        .i_clk(clk), .i_rst(rst), .i_data(d_data), .i_valid(d_valid), .o_ready(d_ready),
        .o_tx_data(d_tx_data), .o_tx_valid(d_tx_valid), .i_tx_ready(tx_ready), .o_busy(d_busy)
    );

    hex_frame_sequencer #(.NIBBLES(4), .PREFIX_0X(1'b1), .SEND_CRLF(1'b0)) u_pfx (
        .i_clk(clk), .i_rst(rst), .i_data(p_data), .i_valid(p_valid), .o_ready(p_ready),
        .o_tx_data(p_tx_data), .o_tx_valid(p_tx_valid), .i_tx_ready(tx_ready), .o_busy(p_busy)
    );

    hex_frame_sequencer #(.NIBBLES(1), .PREFIX_0X(1'b0), .SEND_CRLF(1'b1)) u_n1 (
        .i_clk(clk), .i_rst(rst), .i_data(n_data), .i_valid(n_valid), .o_ready(n_ready),
        .o_tx_data(n_tx_data), .o_tx_valid(n_tx_valid), .i_tx_ready(tx_ready), .o_busy(n_busy)
    );

    // Advance one clock; outputs are then observed and inputs driven 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_tests++;
        if ({d_ready, d_busy, d_tx_valid, d_tx_data} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_def: got ready=%b busy=%b valid=%b data=%h, expected 1 0 0 00",
                     d_ready, d_busy, d_tx_valid, d_tx_data);
        end
        n_tests++;
        if ({p_ready, p_busy, p_tx_valid, p_tx_data} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_pfx: got ready=%b busy=%b valid=%b data=%h, expected 1 0 0 00",
                     p_ready, p_busy, p_tx_valid, p_tx_data);
        end
        n_tests++;
        if ({n_ready, n_busy, n_tx_valid, n_tx_data} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_n1: got ready=%b busy=%b valid=%b data=%h, expected 1 0 0 00",
                     n_ready, n_busy, n_tx_valid, n_tx_data);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_default_frame();
        logic [7:0] exp [6] = '{8'h31, 8'h41, 8'h32, 8'h46, 8'h0D, 8'h0A};
        tx_ready = 1'b1;
        d_data   = 16'h1A2F;
        d_valid  = 1'b1;
        tick();
        d_valid  = 1'b0;
        for (int k = 0; k < 6; k++) begin
            n_tests++;
            if ({d_tx_valid, d_tx_data, d_ready, d_busy} !== {1'b1, exp[k], 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL default_char%0d: got valid=%b data=%h ready=%b busy=%b, expected 1 %h 0 1",
                         k, d_tx_valid, d_tx_data, d_ready, d_busy, exp[k]);
            end
            tick();
        end
        n_tests++;
        if ({d_tx_valid, d_ready, d_busy} !== 3'b010) begin
            n_fail++;
            $display("FAIL default_end: got valid=%b ready=%b busy=%b, expected 0 1 0",
                     d_tx_valid, d_ready, d_busy);
        end
    endtask

    task automatic test_prefix();
        logic [7:0] exp [6] = '{8'h30, 8'h78, 8'h30, 8'h30, 8'h46, 8'h30};
        tx_ready = 1'b1;
        p_data   = 16'h00F0;
        p_valid  = 1'b1;
        tick();
        p_valid  = 1'b0;
        for (int k = 0; k < 6; k++) begin
            n_tests++;
            if ({p_tx_valid, p_tx_data} !== {1'b1, exp[k]}) begin
                n_fail++;
                $display("FAIL prefix_char%0d: got valid=%b data=%h, expected 1 %h",
                         k, p_tx_valid, p_tx_data, exp[k]);
            end
            tick();
        end
        n_tests++;
        if ({p_tx_valid, p_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL prefix_end: got valid=%b ready=%b, expected 0 1", p_tx_valid, p_ready);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp [6] = '{8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
        tx_ready = 1'b1;
        d_data   = 16'hBEEF;
        d_valid  = 1'b1;
        tick();
        d_valid  = 1'b0;
        n_tests++;
        if ({d_tx_valid, d_tx_data} !== {1'b1, exp[0]}) begin
            n_fail++;
            $display("FAIL bp_char0: got valid=%b data=%h, expected 1 %h", d_tx_valid, d_tx_data, exp[0]);
        end
        tick();
        tx_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            tick();
            n_tests++;
            if ({d_tx_valid, d_tx_data} !== {1'b1, 8'h45}) begin
                n_fail++;
                $display("FAIL bp_stall%0d: got valid=%b data=%h, expected 1 45", s, d_tx_valid, d_tx_data);
            end
        end
        tx_ready = 1'b1;
        for (int k = 1; k < 6; k++) begin
            n_tests++;
            if ({d_tx_valid, d_tx_data} !== {1'b1, exp[k]}) begin
                n_fail++;
                $display("FAIL bp_char%0d: got valid=%b data=%h, expected 1 %h",
                         k, d_tx_valid, d_tx_data, exp[k]);
            end
            tick();
        end
        n_tests++;
        if ({d_tx_valid, d_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL bp_end: got valid=%b ready=%b, expected 0 1", d_tx_valid, d_ready);
        end
    endtask

    task automatic test_busy_input();
        logic [7:0] exp_a [6] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A};
        logic [7:0] exp_b [6] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h0D, 8'h0A};
        tx_ready = 1'b1;
        d_data   = 16'hABCD;
        d_valid  = 1'b1;
        tick();
        d_valid  = 1'b0;
        for (int k = 0; k < 6; k++) begin
            n_tests++;
            if ({d_tx_valid, d_tx_data, d_ready} !== {1'b1, exp_a[k], 1'b0}) begin
                n_fail++;
                $display("FAIL busy_a_char%0d: got valid=%b data=%h ready=%b, expected 1 %h 0",
                         k, d_tx_valid, d_tx_data, d_ready, exp_a[k]);
            end
            if (k == 1) begin
                d_data  = 16'h1234;
                d_valid = 1'b1;
            end
            tick();
        end
        n_tests++;
        if ({d_tx_valid, d_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL busy_gap: got valid=%b ready=%b, expected 0 1", d_tx_valid, d_ready);
        end
        tick();
        d_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            n_tests++;
            if ({d_tx_valid, d_tx_data} !== {1'b1, exp_b[k]}) begin
                n_fail++;
                $display("FAIL busy_b_char%0d: got valid=%b data=%h, expected 1 %h",
                         k, d_tx_valid, d_tx_data, exp_b[k]);
            end
            tick();
        end
        n_tests++;
        if ({d_tx_valid, d_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL busy_end: got valid=%b ready=%b, expected 0 1", d_tx_valid, d_ready);
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] exp [6] = '{8'h30, 8'h30, 8'h30, 8'h39, 8'h0D, 8'h0A};
        tx_ready = 1'b1;
        d_data   = 16'h5555;
        d_valid  = 1'b1;
        tick();
        d_valid  = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if ({d_tx_valid, d_tx_data} !== {1'b1, 8'h35}) begin
                n_fail++;
                $display("FAIL rst_pre_char%0d: got valid=%b data=%h, expected 1 35", k, d_tx_valid, d_tx_data);
            end
            if (k == 0) tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++;
        if ({d_tx_valid, d_ready, d_busy} !== 3'b010) begin
            n_fail++;
            $display("FAIL rst_mid: got valid=%b ready=%b busy=%b, expected 0 1 0", d_tx_valid, d_ready, d_busy);
        end
        d_data  = 16'h0009;
        d_valid = 1'b1;
        tick();
        d_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            n_tests++;
            if ({d_tx_valid, d_tx_data} !== {1'b1, exp[k]}) begin
                n_fail++;
                $display("FAIL rst_post_char%0d: got valid=%b data=%h, expected 1 %h",
                         k, d_tx_valid, d_tx_data, exp[k]);
            end
            tick();
        end
        n_tests++;
        if ({d_tx_valid, d_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL rst_post_end: got valid=%b ready=%b, expected 0 1", d_tx_valid, d_ready);
        end
    endtask

    task automatic test_single_nibble();
        logic [7:0] exp [3] = '{8'h43, 8'h0D, 8'h0A};
        tx_ready = 1'b1;
        n_data   = 4'hC;
        n_valid  = 1'b1;
        tick();
        n_valid  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if ({n_tx_valid, n_tx_data} !== {1'b1, exp[k]}) begin
                n_fail++;
                $display("FAIL n1_char%0d: got valid=%b data=%h, expected 1 %h",
                         k, n_tx_valid, n_tx_data, exp[k]);
            end
            tick();
        end
        n_tests++;
        if ({n_tx_valid, n_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL n1_end: got valid=%b ready=%b, expected 0 1", n_tx_valid, n_ready);
        end
    endtask

    // Guard against a stuck simulation
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion before 200000 ns");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        tx_ready = 1'b1;
        d_data   = '0;
        d_valid  = 1'b0;
        p_data   = '0;
        p_valid  = 1'b0;
        n_data   = '0;
        n_valid  = 1'b0;
        #1;
        test_reset();
        test_default_frame();
        tick();
        test_prefix();
        tick();
        test_backpressure();
        tick();
        test_busy_input();
        tick();
        test_reset_midframe();
        tick();
        test_single_nibble();
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_hex_frame_sequencer
`default_nettype wire

// File: doc/hex_frame_sequencer.md
Name: hex_frame_sequencer

Overview:
Sequences a captured N-nibble data word (e.g. a 16-bit ADS1115 conversion result) into a stream of ASCII hex characters for the UART transmitter.
- Output order: optional "0x" prefix, hex digits MSB-nibble first, optional CR LF terminator.
- Sits between the ADC polling controller (word source) and the UART TX (byte sink).
- Owns the nibble-select/convert datapath and both valid/ready handshakes.

Parameters:
NIBBLES, 4, number of hex digits emitted per word (1..8); input data width = 4*NIBBLES
PREFIX_0X, 0, 1 = emit "0" then "x" before the digits
SEND_CRLF, 1, 1 = emit 0x0D then 0x0A after the digits

Ports:
i_clk  input  1  system clock, all logic rising-edge
i_rst  input  1  synchronous reset, active-high
i_data  input  4*NIBBLES  word to print
i_valid  input  1  source offers i_data
o_ready  output  1  block idle; word accepted on i_valid && o_ready
o_tx_data  output  8  ASCII character to UART
o_tx_valid  output  1  o_tx_data valid
i_tx_ready  input  1  UART accepts the character (transfer on o_tx_valid && i_tx_ready)
o_busy  output  1  frame in progress (inverse of o_ready)

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is synchronous and active-high.
- Reset values: state IDLE, o_ready=1, o_busy=0, o_tx_valid=0, o_tx_data=0x00, nibble index=NIBBLES-1, captured word=0.
- States:
  - IDLE -> PFX0 (if PREFIX_0X), else -> HEX, on input accept.
  - PFX0 ("0") -> PFX1 ("x") -> HEX.
  - HEX: digit at index idx, via nibble conversion 0-9 -> 0x30-0x39, A-F -> 0x41-0x46, uppercase.
  - HEX -> CR when idx==0 and SEND_CRLF, else -> IDLE.
  - CR (0x0D) -> LF (0x0A) -> IDLE.
- State advances only on a TX handshake (o_tx_valid && i_tx_ready).
- HEX index: idx decrements per handshake, NIBBLES-1 down to 0. Reloads to NIBBLES-1 on input accept.
- Input accept: at cycle N, i_data is registered and the FSM leaves IDLE. o_tx_valid=1 with the first character at N+1. i_valid while busy is ignored; the source must hold it.
- Output registers: o_tx_valid and o_tx_data are registered.
- Backpressure:
  - While o_tx_valid=1 and i_tx_ready=0, o_tx_data is held stable and o_tx_valid stays 1.
  - Valid is never withdrawn without a handshake, except on reset.
- Throughput: with i_tx_ready tied high, one character per cycle with no bubbles. Frame length = NIBBLES + 2*PREFIX_0X + 2*SEND_CRLF.
- Frame end:
  - The last handshake returns the FSM to IDLE. o_tx_valid=0 and o_ready=1 the following cycle.
  - No same-cycle reaccept: the minimum gap between frames is one idle cycle.
- Captured word is frozen for the whole frame; i_data changes mid-frame have no effect.
- Reset mid-frame: the next cycle is IDLE with o_tx_valid=0. The partial frame is abandoned with no terminator.
- NIBBLES=1: HEX lasts exactly one character.

Decomposition:
- Shared package hex_frame_pkg:
  - ASCII constants ASCII_0=0x30, ASCII_X=0x78, ASCII_CR=0x0D, ASCII_LF=0x0A.
  - State encoding localparams IDLE, PFX0, PFX1, HEX, CR, LF.
- Sub-module: hex_to_ascii (existing 4-bit-to-ASCII combinational converter), driven by the selected nibble of the captured word.
- Output mux and FSM remain in this block.

Test Plan:
- Defaults, i_tx_ready=1, send 0x1A2F -> chars 0x31,0x41,0x32,0x46,0x0D,0x0A on 6 consecutive cycles starting at accept+1; o_ready high again 1 cycle after the last character.
- PREFIX_0X=1, SEND_CRLF=0, send 0x00F0 -> "0","x","0","0","F","0" (0x30,0x78,0x30,0x30,0x46,0x30), then IDLE.
- Backpressure: send 0xBEEF, hold i_tx_ready=0 for 5 cycles during the 2nd char -> o_tx_data stays 0x45 with o_tx_valid=1, and the sequence completes unchanged.
- Busy input: assert i_valid with 0x1234 mid-frame of 0xABCD -> o_ready=0, only "ABCD\r\n" emitted; 0x1234 is accepted after return to IDLE and printed next.
- Reset mid-frame: assert i_rst after 2 characters of 0x5555 -> next cycle o_tx_valid=0, o_ready=1; a fresh 0x0009 then prints "0009\r\n".
- NIBBLES=1, send 0xC -> 0x43,0x0D,0x0A.
